// File: rtl/core_pkg.sv
// core_pkg: shared core-wide widths and the hazard controller state type.
//   REG_ADDR_WIDTH : architectural register address width
//   DATA_WIDTH     : datapath width, also the width of the perf counters
//   BUBBLE_W       : width of the redirect bubble down-counter (0..3)
//   hz_state_e     : hazard controller states
package core_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int BUBBLE_W       = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EX_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard compare.
// Flags when the load held in ID/EX writes a register (other than x0) that
// the instruction in ID actually reads.
//   rs1_addr/rs2_addr : ID source register addresses
//   use_rs1/use_rs2   : ID instruction reads the matching source
//   mem_read          : ID/EX holds a load
//   rd_addr           : ID/EX destination register
//   load_use          : hazard present
module load_use_detect
  import core_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic                      use_rs1,
  input  logic                      use_rs2,
  input  logic                      mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic                      load_use
);

  logic [REG_ADDR_WIDTH-1:0] src_addr [2];
  logic [1:0]                src_use;
  logic [1:0]                src_hit;

  assign src_addr[0] = rs1_addr;
  assign src_addr[1] = rs2_addr;
  assign src_use     = {use_rs2, use_rs1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] & (src_addr[gi] == rd_addr);
    end
  endgenerate

  // x0 is never a real destination, so a load into it cannot cause a hazard.
  assign load_use = mem_read & (rd_addr != '0) & (|src_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for a 5-stage in-order pipe.
// Priority: redirect > multicycle EX busy > load-use. Outputs are
// combinational from state and inputs so a hazard acts in the cycle it is
// seen. A redirect flushes IF/ID for 1 + REDIRECT_BUBBLES cycles.
//   clk, rst                    : clock, asynchronous active-high reset
//   id_rs1_addr/id_rs2_addr     : ID source registers
//   id_use_rs1/id_use_rs2       : ID instruction reads rs1/rs2
//   ex_mem_read, ex_rd_addr     : load flag and destination in ID/EX
//   ex_redirect                 : taken branch / jump resolved in EX
//   ex_busy                     : multicycle EX op still running
//   pc_stall .. ex_mem_flush    : pipeline register controls
//   stall_cnt, flush_cnt        : cycles with pc_stall / if_id_flush
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_redirect,
  input  logic                      ex_busy,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_stall,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
);

  localparam logic [BUBBLE_W-1:0]   BUBBLE_LOAD = BUBBLE_W'(REDIRECT_BUBBLES);
  localparam logic [BUBBLE_W-1:0]   BUBBLE_ONE  = BUBBLE_W'(1);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE     = DATA_WIDTH'(1);

  hz_state_e             state_reg, state_next;
  logic [BUBBLE_W-1:0]   bubble_reg, bubble_next;
  logic [DATA_WIDTH-1:0] stall_cnt_reg, flush_cnt_reg;
  logic                  load_use;

  load_use_detect u_load_use_detect (
    .rs1_addr (id_rs1_addr),
    .rs2_addr (id_rs2_addr),
    .use_rs1  (id_use_rs1),
    .use_rs2  (id_use_rs2),
    .mem_read (ex_mem_read),
    .rd_addr  (ex_rd_addr),
    .load_use (load_use)
  );

  // Each branch sets either the stall or the flush of a given register,
  // never both, so no register ever sees conflicting controls.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_next   = state_reg;
    bubble_next  = bubble_reg;

    if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (REDIRECT_BUBBLES == 0) begin
        state_next  = RUN;
        bubble_next = '0;
      end else begin
        state_next  = REDIRECT;
        bubble_next = BUBBLE_LOAD;
      end
    end else if (state_reg == REDIRECT) begin
      // Wrong-path fetches keep arriving in IF/ID until the counter runs out.
      if_id_flush = 1'b1;
      if (bubble_reg <= BUBBLE_ONE) begin
        state_next  = RUN;
        bubble_next = '0;
      end else begin
        bubble_next = bubble_reg - BUBBLE_ONE;
      end
    end else if (ex_busy) begin
      // Freeze everything upstream of EX and keep MEM fed with bubbles.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
      state_next   = EX_WAIT;
    end else begin
      // RUN, or the first non-busy cycle of EX_WAIT: load-use still applies.
      state_next = RUN;
      if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end

    // Reset holds every control low even between clock edges.
    if (rst) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      state_next   = RUN;
      bubble_next  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      bubble_reg    <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      bubble_reg <= bubble_next;
      if (pc_stall)    stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      if (if_id_flush) flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (REDIRECT_BUBBLES = 2).
// Each row of stimulus pushes its expected controls and counter values onto a
// scoreboard queue; the entry is popped and compared on the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110010; // pc/if_id stall + id_ex flush
  localparam logic [5:0] C_BUSY  = 6'b110101; // full stall + ex_mem flush
  localparam logic [5:0] C_REDIR = 6'b001010; // if_id + id_ex flush
  localparam logic [5:0] C_RFL   = 6'b001000; // if_id flush only

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       redir;
    logic       busy;
    logic [5:0] ctrl;
  } row_t;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic        ex_redirect = 1'b0, ex_busy = 1'b0;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush;
  logic [31:0] stall_cnt, flush_cnt;

  exp_t        sb_q[$];
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd_addr   (ex_rd_addr),
    .ex_redirect  (ex_redirect),
    .ex_busy      (ex_busy),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  wire [5:0] ctrl_obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush};

  function automatic row_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic mr,
                              input logic [4:0] rd, input logic redir,
                              input logic busy, input logic [5:0] ctrl);
    row_t r;
    r = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, mr: mr, rd: rd,
          redir: redir, busy: busy, ctrl: ctrl};
    return r;
  endfunction

  // Drive one cycle of stimulus just after the rising edge and record what
  // the bench expects to see on the following falling edge.
  task automatic apply(input row_t r);
    exp_t e;
    @(posedge clk);
    #1;
    id_rs1_addr = r.rs1;
    id_rs2_addr = r.rs2;
    id_use_rs1  = r.u1;
    id_use_rs2  = r.u2;
    ex_mem_read = r.mr;
    ex_rd_addr  = r.rd;
    ex_redirect = r.redir;
    ex_busy     = r.busy;
    e = '{ctrl: r.ctrl, st: m_stall, fl: m_flush};
    sb_q.push_back(e);
    if (r.ctrl[5]) m_stall = m_stall + 32'd1;
    if (r.ctrl[3]) m_flush = m_flush + 32'd1;
  endtask

  row_t idle;

  task automatic test_reset();
    rst = 1'b1;
    // Load-use inputs present during reset must not leak to the outputs.
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_use_rs2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ctrl_obs !== C_NONE) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=%b", ctrl_obs, C_NONE);
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
    $display("test_reset ctrl=%b stall_cnt=%0d flush_cnt=%0d", ctrl_obs, stall_cnt, flush_cnt);
    ex_mem_read = 1'b0; ex_rd_addr = '0; id_rs2_addr = '0; id_use_rs2 = 1'b0;
    rst = 1'b0;
    m_stall = '0;
    m_flush = '0;
  endtask

  task automatic test_load_use();
    row_t rows[4];
    exp_t e;
    rows[0] = mk(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_LU);
    rows[1] = idle;
    rows[2] = mk(5'd7, 5'd1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, C_LU);
    rows[3] = idle;
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (ctrl_obs !== e.ctrl || stall_cnt !== e.st || flush_cnt !== e.fl) begin
        errors++;
        $display("FAIL load_use[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i,
                 ctrl_obs, stall_cnt, flush_cnt, e.ctrl, e.st, e.fl);
      end else
        $display("test_load_use[%0d] ctrl=%b stall_cnt=%0d flush_cnt=%0d", i, ctrl_obs, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_no_hazard();
    row_t rows[3];
    exp_t e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_NONE); // x0 load
    rows[1] = mk(5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, C_NONE); // rs2 unused
    rows[2] = mk(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, C_NONE); // not a load
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (ctrl_obs !== e.ctrl || stall_cnt !== e.st || flush_cnt !== e.fl) begin
        errors++;
        $display("FAIL no_hazard[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i,
                 ctrl_obs, stall_cnt, flush_cnt, e.ctrl, e.st, e.fl);
      end else
        $display("test_no_hazard[%0d] ctrl=%b stall_cnt=%0d flush_cnt=%0d", i, ctrl_obs, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_redirect();
    row_t rows[10];
    exp_t e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_REDIR);
    rows[1] = idle; rows[1].ctrl = C_RFL;
    rows[2] = idle; rows[2].ctrl = C_RFL;
    rows[3] = idle;
    // A second redirect inside the bubble window restarts it.
    rows[4] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_REDIR);
    rows[5] = idle; rows[5].ctrl = C_RFL;
    rows[6] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_REDIR);
    rows[7] = idle; rows[7].ctrl = C_RFL;
    rows[8] = idle; rows[8].ctrl = C_RFL;
    rows[9] = idle;
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (ctrl_obs !== e.ctrl || stall_cnt !== e.st || flush_cnt !== e.fl) begin
        errors++;
        $display("FAIL redirect[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i,
                 ctrl_obs, stall_cnt, flush_cnt, e.ctrl, e.st, e.fl);
      end else
        $display("test_redirect[%0d] ctrl=%b stall_cnt=%0d flush_cnt=%0d", i, ctrl_obs, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_busy_load_use();
    row_t rows[6];
    row_t lu_busy;
    exp_t e;
    lu_busy = mk(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, C_BUSY);
    for (int i = 0; i < 4; i++) rows[i] = lu_busy;
    rows[4] = mk(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_LU);
    rows[5] = idle;
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (ctrl_obs !== e.ctrl || stall_cnt !== e.st || flush_cnt !== e.fl) begin
        errors++;
        $display("FAIL busy_lu[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i,
                 ctrl_obs, stall_cnt, flush_cnt, e.ctrl, e.st, e.fl);
      end else
        $display("test_busy_load_use[%0d] ctrl=%b stall_cnt=%0d flush_cnt=%0d", i, ctrl_obs, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_redirect_busy();
    row_t rows[4];
    exp_t e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, C_REDIR);
    rows[1] = idle; rows[1].ctrl = C_RFL;
    rows[2] = idle; rows[2].ctrl = C_RFL;
    rows[3] = idle;
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (ctrl_obs !== e.ctrl || stall_cnt !== e.st || flush_cnt !== e.fl) begin
        errors++;
        $display("FAIL redir_busy[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i,
                 ctrl_obs, stall_cnt, flush_cnt, e.ctrl, e.st, e.fl);
      end else
        $display("test_redirect_busy[%0d] ctrl=%b stall_cnt=%0d flush_cnt=%0d", i, ctrl_obs, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_reset_mid_redirect();
    row_t rows[2];
    exp_t e;
    rows[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_REDIR);
    rows[1] = idle; rows[1].ctrl = C_RFL;
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (ctrl_obs !== e.ctrl || stall_cnt !== e.st || flush_cnt !== e.fl) begin
        errors++;
        $display("FAIL rst_mid[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i,
                 ctrl_obs, stall_cnt, flush_cnt, e.ctrl, e.st, e.fl);
      end else
        $display("test_reset_mid_redirect[%0d] ctrl=%b flush_cnt=%0d", i, ctrl_obs, flush_cnt);
    end
    // Second REDIRECT cycle: reset asynchronously between edges.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl_obs !== C_NONE || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_async got=%b/%0d/%0d want=%b/0/0", ctrl_obs, stall_cnt, flush_cnt, C_NONE);
    end else
      $display("test_reset_mid_redirect async ctrl=%b stall_cnt=%0d flush_cnt=%0d", ctrl_obs, stall_cnt, flush_cnt);
    @(negedge clk);
    rst = 1'b0;
    m_stall = '0;
    m_flush = '0;
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      apply(idle);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (ctrl_obs !== e.ctrl || stall_cnt !== e.st || flush_cnt !== e.fl) begin
        errors++;
        $display("FAIL rst_release[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i,
                 ctrl_obs, stall_cnt, flush_cnt, e.ctrl, e.st, e.fl);
      end else
        $display("test_reset_mid_redirect post[%0d] ctrl=%b flush_cnt=%0d", i, ctrl_obs, flush_cnt);
    end
  endtask

  initial begin
    idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_NONE);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect();
    test_busy_load_use();
    test_redirect_busy();
    test_reset_mid_redirect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout got=running want=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REDIRECT_BUBBLES, default 1, meaning the extra IF/ID flush cycles after a redirect (range 0..3).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_rs1_addr / id_rs2_addr  input  REG_ADDR_WIDTH each  source registers of the instruction in ID.
REQ-005 SHALL have port id_use_rs1 / id_use_rs2  input  1 each  the ID instruction reads rs1 / rs2.
REQ-006 SHALL have port ex_mem_read  input  1  the ID/EX register holds a load (MemRead).
REQ-007 SHALL have port ex_rd_addr  input  REG_ADDR_WIDTH  destination register held in ID/EX.
REQ-008 SHALL have port ex_redirect  input  1  EX resolved a taken Branch or a Jump.
REQ-009 SHALL have port ex_busy  input  1  multicycle EX operation not yet complete.
REQ-010 SHALL have ports pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush  output  1 each  pipeline register controls.
REQ-011 SHALL have ports stall_cnt, flush_cnt  output  32 each  performance counters.

Function
REQ-012 SHALL implement states RUN, EX_WAIT, REDIRECT, encoded as hz_state_e.
REQ-013 SHALL define load_use = ex_mem_read & (ex_rd_addr != 0) & ((id_use_rs1 & id_rs1_addr == ex_rd_addr) | (id_use_rs2 & id_rs2_addr == ex_rd_addr)).
REQ-014 SHALL resolve conditions in this priority: ex_redirect > ex_busy > load_use; the highest active condition alone drives the outputs.
REQ-015 SHALL drive outputs combinationally from the current state and inputs, with no input-to-output register latency.
REQ-016 On ex_redirect in any state: if_id_flush=1, id_ex_flush=1, all stalls 0, next state REDIRECT, bubble counter loaded with REDIRECT_BUBBLES.
REQ-017 If REDIRECT_BUBBLES=0, a redirect SHALL go to RUN instead of REDIRECT.
REQ-018 In REDIRECT without a new redirect: if_id_flush=1, counter decrements, return to RUN when the counter reaches 1; a new redirect reloads the counter.
REQ-019 On ex_busy (no redirect): pc_stall, if_id_stall and id_ex_stall are 1, ex_mem_flush=1, and the state is EX_WAIT while ex_busy remains high.
REQ-020 EX_WAIT SHALL return to RUN in the first cycle ex_busy is low, applying REQ-013 in that same cycle.
REQ-021 On load_use only: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble), and the state stays RUN.
REQ-022 A stall and a flush SHALL never both be asserted on the same register in the same cycle.
REQ-023 stall_cnt SHALL increment each cycle pc_stall=1, and flush_cnt each cycle if_id_flush=1; both wrap modulo 2^32.
REQ-024 A REDIRECT-state flush cycle SHALL count as a flush even when there are no inputs.

Reset
REQ-025 While rst is high: state RUN, bubble counter 0, both counters 0, all control outputs 0, regardless of clk.
REQ-026 Reset asserted mid-EX_WAIT or mid-REDIRECT SHALL abandon the sequence, with no residual flush after release.

Structure
REQ-027 hz_state_e SHALL reside in core_pkg, and REG_ADDR_WIDTH and DATA_WIDTH SHALL be reused from core_pkg.
REQ-028 The load_use compare SHALL be a combinational sub-module load_use_detect, instantiated once.

Verification
REQ-029 The bench SHALL cover: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5, id_use_rs2=1 -> for one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1, stall_cnt=1.
REQ-030 The bench SHALL cover: same as REQ-029 but ex_rd_addr=0 -> all outputs 0.
REQ-031 The bench SHALL cover: ex_redirect pulse, REDIRECT_BUBBLES=2 -> if_id_flush=1 for 3 consecutive cycles, id_ex_flush=1 only in the first, flush_cnt=3.
REQ-032 The bench SHALL cover: ex_busy high for 4 cycles with load_use also true -> 4 cycles of full stall plus ex_mem_flush, then a load-use bubble on cycle 5.
REQ-033 The bench SHALL cover: ex_redirect and ex_busy both high -> redirect flush only, no stall.
REQ-034 The bench SHALL cover: rst pulsed in the second REDIRECT cycle -> outputs 0 immediately, RUN after release, counters 0.
